// File: rtl/ascon_in_loader_if.sv
// Stream-in and operand-out signals for the ASCON input loader.
// Master: word source plus downstream encrypt stage. Slave: the loader.
interface ascon_in_loader_if;
  logic [31:0]  in_data;
  logic         in_valid;
  logic         in_last;
  logic         in_ready;
  logic         done;
  logic [127:0] sk;
  logic [127:0] n;
  logic [127:0] a;
  logic [127:0] p;
  logic         start;
  logic [4:0]   cnt;
  logic         err;

  modport master (
    output in_data, in_valid, in_last, done,
    input  in_ready, sk, n, a, p, start, cnt, err
  );

  modport slave (
    input  in_data, in_valid, in_last, done,
    output in_ready, sk, n, a, p, start, cnt, err
  );
endinterface

// File: rtl/ascon_in_loader.sv
// Collects a 16-word frame into the SK/N/A/P operands and starts the encrypt stage.
// state  | meaning
// S_LOAD | accepting words; in_last must coincide with word 15
// S_FIRE | one-cycle start pulse, operands valid
// S_WAIT | holding operands until the encrypt stage reports done
module ascon_in_loader #(
  parameter int WORDS_PER_FRAME = 16
) (
  input logic              clk,
  input logic              rst_n,
  ascon_in_loader_if.slave bus
);

  typedef enum logic [1:0] {S_LOAD, S_FIRE, S_WAIT} state_t;

  localparam logic [4:0] LAST_IDX = 5'(WORDS_PER_FRAME - 1);

  state_t       state_q, state_d;
  logic [4:0]   cnt_q, cnt_d;
  logic         err_q, err_d;
  logic         rdy_en_q, rdy_en_d;
  logic [127:0] sk_q, sk_d;
  logic [127:0] n_q, n_d;
  logic [127:0] a_q, a_d;
  logic [127:0] p_q, p_d;
  logic         xfer;

  // Slot 0 of a group lands in the most significant word.
  function automatic logic [127:0] put_word(input logic [127:0] op,
                                            input logic [1:0]   slot,
                                            input logic [31:0]  w);
    logic [127:0] r;
    r = op;
    r[{2'd3 - slot, 5'd0} +: 32] = w;
    return r;
  endfunction

  assign bus.in_ready = rdy_en_q && (state_q == S_LOAD);
  assign xfer         = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    rdy_en_d = 1'b1;
    sk_d     = sk_q;
    n_d      = n_q;
    a_d      = a_q;
    p_d      = p_q;
    case (state_q)
      S_LOAD: begin
        if (xfer) begin
          if (bus.in_last != (cnt_q == LAST_IDX)) begin
            cnt_d = 5'd0;
            err_d = 1'b1;
          end else begin
            case (cnt_q[3:2])
              2'd0:    sk_d = put_word(sk_q, cnt_q[1:0], bus.in_data);
              2'd1:    n_d  = put_word(n_q,  cnt_q[1:0], bus.in_data);
              2'd2:    a_d  = put_word(a_q,  cnt_q[1:0], bus.in_data);
              default: p_d  = put_word(p_q,  cnt_q[1:0], bus.in_data);
            endcase
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == LAST_IDX) state_d = S_FIRE;
          end
        end
      end
      S_FIRE: begin
        // done already asserted during the start pulse skips the wait.
        if (bus.done) begin
          state_d = S_LOAD;
          cnt_d   = 5'd0;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.done) begin
          state_d = S_LOAD;
          cnt_d   = 5'd0;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_LOAD;
      cnt_q    <= 5'd0;
      err_q    <= 1'b0;
      rdy_en_q <= 1'b0;
      sk_q     <= '0;
      n_q      <= '0;
      a_q      <= '0;
      p_q      <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      rdy_en_q <= rdy_en_d;
      sk_q     <= sk_d;
      n_q      <= n_d;
      a_q      <= a_d;
      p_q      <= p_d;
    end
  end

  assign bus.start = (state_q == S_FIRE);
  assign bus.err   = err_q;
  assign bus.cnt   = cnt_q;
  assign bus.sk    = sk_q;
  assign bus.n     = n_q;
  assign bus.a     = a_q;
  assign bus.p     = p_q;

endmodule

// File: tb/tb_ascon_in_loader.sv
// Directed and randomized frames for ascon_in_loader, checked every cycle
// against a word-array model of the frame and loader phase.
module tb_ascon_in_loader;

  localparam int PH_LOAD = 0;
  localparam int PH_FIRE = 1;
  localparam int PH_WAIT = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ascon_in_loader_if bus ();
  ascon_in_loader #(.WORDS_PER_FRAME(16)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int          m_phase;
  int          m_len;
  logic [31:0] m_w[16];
  bit          m_alive;
  bit          m_err;
  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;

  function automatic logic [127:0] grp(input int g);
    return {m_w[4*g], m_w[4*g+1], m_w[4*g+2], m_w[4*g+3]};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("in_ready", 128'(bus.in_ready), 128'(m_alive && m_phase == PH_LOAD));
    chk("start",    128'(bus.start),    128'(m_phase == PH_FIRE));
    chk("err",      128'(bus.err),      128'(m_err));
    chk("cnt",      128'(bus.cnt),      128'(m_len));
    chk("sk",       bus.sk, grp(0));
    chk("n",        bus.n,  grp(1));
    chk("a",        bus.a,  grp(2));
    chk("p",        bus.p,  grp(3));
  endtask

  task automatic model_reset();
    m_phase = PH_LOAD;
    m_len   = 0;
    m_alive = 1'b0;
    m_err   = 1'b0;
    for (int i = 0; i < 16; i++) m_w[i] = 32'h0;
  endtask

  // One clock: apply inputs, advance the model over the edge, compare.
  task automatic cycle(input bit v, input logic [31:0] d, input bit l, input bit dn);
    bit rdy;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.done     = dn;
    rdy = m_alive && (m_phase == PH_LOAD);
    @(posedge clk);
    #1;
    m_err = 1'b0;
    case (m_phase)
      PH_LOAD: if (v && rdy) begin
        if (l && m_len == 15) begin
          m_w[15] = d;
          m_len   = 16;
          m_phase = PH_FIRE;
        end else if (l || m_len == 15) begin
          m_len = 0;
          m_err = 1'b1;
        end else begin
          m_w[m_len] = d;
          m_len++;
        end
      end
      PH_FIRE: begin
        m_phase = dn ? PH_LOAD : PH_WAIT;
        if (dn) m_len = 0;
      end
      default: if (dn) begin
        m_phase = PH_LOAD;
        m_len   = 0;
      end
    endcase
    m_alive = 1'b1;
    check_all();
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_data  = 32'h0;
    bus.in_last  = 1'b0;
    bus.done     = 1'b0;
  endtask

  task automatic hw_reset();
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all();
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check_all();
  endtask

  // Random frame with random idle gaps; done toggles randomly while loading.
  task automatic random_frame(output int starts);
    starts = 0;
    for (int i = 0; i < 16; i++) begin
      int gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) begin
        cycle(1'b0, $urandom, 1'b0, 1'($urandom));
        if (bus.start) starts++;
      end
      cycle(1'b1, $urandom, i == 15, 1'($urandom));
      if (bus.start) starts++;
    end
  endtask

  initial begin
    int st;
    int starts;
    idle_inputs();
    model_reset();
    #1;
    check_all();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    #1;
    check_all();
    cycle(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0);

    // Counting-pattern frame, back to back.
    for (int i = 0; i < 16; i++) cycle(1'b1, 32'(i), i == 15, 1'b0);
    chk("sf_start", 128'(bus.start), 128'(1));
    chk("sf_sk", bus.sk, 128'h00000000_00000001_00000002_00000003);
    chk("sf_p",  bus.p,  128'h0000000C_0000000D_0000000E_0000000F);
    chk("sf_cnt", 128'(bus.cnt), 128'(16));

    // Source keeps pushing while the encrypt stage is busy.
    for (int i = 0; i < 20; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    chk("bp_ready", 128'(bus.in_ready), 128'(0));
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("bp_cnt", 128'(bus.cnt), 128'(0));
    chk("bp_ready_after", 128'(bus.in_ready), 128'(1));

    // Every-other-cycle valid; start lands 31 cycles after first transfer.
    st = -1;
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, 32'(i), i == 15, 1'b0);
      if (bus.start && st < 0) st = 2 * i + 1;
      if (i < 15) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    end
    chk("stall_latency", 128'(st), 128'(31));
    chk("stall_sk", bus.sk, 128'h00000000_00000001_00000002_00000003);

    // done during the start pulse returns straight to loading.
    cycle(1'b0, 32'h0, 1'b0, 1'b1);
    chk("fire_done_ready", 128'(bus.in_ready), 128'(1));

    // Early last on word 5.
    for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    cycle(1'b1, 32'hAAAA_5555, 1'b1, 1'b0);
    chk("early_err", 128'(bus.err), 128'(1));
    chk("early_cnt", 128'(bus.cnt), 128'(0));
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // Missing last on word 15.
    for (int i = 0; i < 15; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    cycle(1'b1, 32'h5555_AAAA, 1'b0, 1'b0);
    chk("late_err", 128'(bus.err), 128'(1));
    chk("late_start", 128'(bus.start), 128'(0));
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    // Reset after word 9, then a clean frame.
    for (int i = 0; i < 10; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
    hw_reset();
    cycle(1'b0, 32'h0, 1'b0, 1'b0);
    random_frame(starts);
    chk("post_rst_starts", 128'(starts), 128'(1));

    // Randomized frames with random done delay.
    for (int f = 0; f < 4; f++) begin
      int dly = int'($urandom_range(0, 3));
      for (int k = 0; k < dly; k++) cycle(1'($urandom), $urandom, 1'b0, 1'b0);
      cycle(1'($urandom), $urandom, 1'b0, 1'b1);
      random_frame(starts);
      chk("rand_starts", 128'(starts), 128'(1));
    end

    // Reset while waiting on done.
    cycle(1'b1, $urandom, 1'b0, 1'b0);
    hw_reset();
    cycle(1'b0, 32'h0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
